lift_key_sequencer: RTL
=======================

Name: lift_key_sequencer

Overview:
- Upstream stage of the time-windowed locked lift controller; drives its 14 key inputs.
- Holds NUM_KEYS key words loaded over a valid/ready port.
- On start, steps a phase counter in lockstep with the controller's 0..31 window counter and presents the key for the current window.
- Supports phase resynchronisation, halt, and clear/reload.

Parameters:
- KEY_W, 14, width of one key word.
- NUM_KEYS, 4, number of key slots / time windows.
- WINDOW, 8, cycles per window (power of two).
- PHASE_W, 5, width of phase counter; must equal log2(NUM_KEYS*WINDOW).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  key beat valid.
- load_data  in  KEY_W  key word; beats fill slot 0,1,2,3 in order.
- load_ready  out  1  sequencer accepts a key beat.
- start  in  1  begin sequencing (honoured in READY only).
- halt  in  1  stop sequencing, return to READY.
- sync  in  1  force phase to 0 (honoured in RUN only).
- clear  in  1  discard load progress, return to IDLE.
- key_out  out  KEY_W  current key; key_out[KEY_W-1-i] drives keyinput i (MSB = keyinput0).
- key_valid  out  1  key_out is meaningful.
- window  out  2  current slot index = phase / WINDOW.
- phase  out  PHASE_W  current phase 0..NUM_KEYS*WINDOW-1.

Behaviour:
- One clock, synchronous active-high reset; all state is registered.
- Reset, applicable at any time including mid-load or mid-RUN:
  - state=IDLE, wr_idx=0, all slots=0.
  - key_out=0, key_valid=0, phase=0, window=0, load_ready=0 in the reset cycle.
- States:
  - IDLE: load_ready=1. A beat is accepted on a cycle with load_valid && load_ready; it writes slot[wr_idx] and wr_idx++. The beat accepted at wr_idx=NUM_KEYS-1 moves to READY next cycle, and load_ready drops that cycle.
  - READY: load_ready=0; load_valid is ignored. start moves to RUN.
  - RUN: each cycle phase <= phase+1. At phase NUM_KEYS*WINDOW-1 it wraps to 0.
- key_out is registered:
  - In RUN, key_out = slot[next_phase / WINDOW] and is updated on the same edge as phase, so key_out always equals slot[window] in the same cycle.
  - key_valid=1 throughout RUN.
- Start latency: start sampled high in READY at edge N → at edge N+1 state=RUN, phase=0, key_out=slot0, key_valid=1.
- sync in RUN: next phase=0 and key_out=slot0, regardless of current phase. sync at phase 0 keeps phase 0 for one extra cycle.
- halt in RUN: next state=READY, key_out=0, key_valid=0, phase=0. Slots are retained, so start reuses the same keys.
- clear in any state: next state=IDLE, wr_idx=0, outputs as in reset, slots retained until overwritten.
- Priority in one cycle: rst > clear > halt > sync > start/advance. start in RUN or IDLE is ignored; sync/halt outside RUN are ignored.
- Load at the wr_idx=NUM_KEYS-1 boundary: exactly NUM_KEYS beats are accepted; no extra beat is absorbed.
- Phase arithmetic is unsigned, modulo NUM_KEYS*WINDOW; window = phase[PHASE_W-1 -: 2].

Decomposition:
- Package lift_lock_pkg:
  - constants KEY_W, NUM_KEYS, WINDOW, PHASE_W, PERIOD = NUM_KEYS*WINDOW;
  - state enum {IDLE, READY, RUN};
  - key word typedef.
- One sub-module, key_slot_file: NUM_KEYS×KEY_W register file with synchronous write port (we, widx, wdata) and combinational read port (ridx), reset-cleared.
- FSM and phase counter live in lift_key_sequencer.

Test Plan:
1. Load 0x0694, 0x2102, 0x0033, 0x10F4 with continuous load_valid → 4 accepts, load_ready low from the 5th cycle, state READY, key_valid=0.
2. start after case 1 → for 32 cycles, key_out = 0x0694 during phase 0-7, 0x2102 during 8-15, 0x0033 during 16-23, 0x10F4 during 24-31; phase wraps 31→0 with key_out back to 0x0694; key_out[13]=0 and key_out[10]=1 for slot0 (keyinput0=0, keyinput3=1).
3. sync at phase 13 → next cycle phase=0, key_out=0x0694, window=0; normal stepping resumes.
4. halt and sync asserted together at phase 20 → next cycle READY, key_valid=0, key_out=0; start then gives phase 0, key_out 0x0694.
5. rst at phase 27, then load_valid with 0x3FFF → reset cycle outputs all 0; all slots read 0 before reload; first accepted beat writes slot0=0x3FFF.
6. Gapped load_valid (1,0,1,1,0,1) plus clear after 2 beats → wr_idx returns to 0; the next 4 beats fill slots 0-3; start in IDLE is ignored.

Source files
------------

// File: rtl/lift_lock_pkg.sv
// Shared constants and types for the lift key sequencer: key width, slot count,
// window timing and the sequencer state encoding.
package lift_lock_pkg;

  localparam int KEY_W    = 14;
  localparam int NUM_KEYS = 4;
  localparam int WINDOW   = 8;
  localparam int PHASE_W  = 5;
  localparam int PERIOD   = NUM_KEYS * WINDOW;
  localparam int IDX_W    = $clog2(NUM_KEYS);

  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Slot index for a phase; WINDOW is a power of two so this is just the top bits.
  function automatic idx_t window_of(input phase_t p);
    return p[PHASE_W-1 -: IDX_W];
  endfunction

endpackage

// File: rtl/key_slot_file.sv
// NUM_KEYS x KEY_W key storage: one synchronous write port, one combinational
// read port, cleared by reset only.
module key_slot_file
  import lift_lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [KEY_W-1:0] wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [KEY_W-1:0] rdata
);

  key_t slot_q [NUM_KEYS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) slot_q[i] <= '0;
    end else if (we) begin
      slot_q[widx] <= wdata;
    end
  end

  assign rdata = slot_q[ridx];

endmodule

// File: rtl/lift_key_sequencer.sv
// Loads NUM_KEYS key words, then presents the key for the current time window
// in lockstep with the downstream lift controller's phase counter.
//
// state | meaning
// IDLE  | accepting key beats into slot[wr_idx]
// READY | all slots loaded, waiting for start
// RUN   | phase stepping, key_out = slot[window]
module lift_key_sequencer
  import lift_lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [KEY_W-1:0]   load_data,
  output logic               load_ready,
  input  logic               start,
  input  logic               halt,
  input  logic               sync,
  input  logic               clear,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic [1:0]         window,
  output logic [PHASE_W-1:0] phase
);

  state_e     state_q, state_n;
  idx_t       wr_idx_q, wr_idx_n;
  phase_t     phase_q, phase_n;
  key_t       key_q, key_n;
  logic       valid_q, valid_n;
  logic       accept;
  key_t       rd_key;

  // A beat is never taken in a cycle that also resets or clears.
  assign load_ready = (state_q == IDLE) && !rst && !clear;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_n  = state_q;
    wr_idx_n = wr_idx_q;
    phase_n  = phase_q;
    if (clear) begin
      state_n  = IDLE;
      wr_idx_n = '0;
      phase_n  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wr_idx_n = wr_idx_q + 1'b1;
            if (wr_idx_q == IDX_W'(NUM_KEYS - 1)) state_n = READY;
          end
        end
        READY: begin
          if (start) begin
            state_n = RUN;
            phase_n = '0;
          end
        end
        RUN: begin
          if (halt) begin
            state_n = READY;
            phase_n = '0;
          end else if (sync) begin
            phase_n = '0;
          end else if (phase_q == PHASE_W'(PERIOD - 1)) begin
            phase_n = '0;
          end else begin
            phase_n = phase_q + 1'b1;
          end
        end
        default: begin
          state_n  = IDLE;
          wr_idx_n = '0;
          phase_n  = '0;
        end
      endcase
    end
  end

  // Look up the key for the phase being entered so key_out lines up with window.
  assign valid_n = (state_n == RUN);
  assign key_n   = valid_n ? rd_key : '0;

  key_slot_file u_slots (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .widx  (wr_idx_q),
    .wdata (load_data),
    .ridx  (window_of(phase_n)),
    .rdata (rd_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      phase_q  <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      wr_idx_q <= wr_idx_n;
      phase_q  <= phase_n;
      key_q    <= key_n;
      valid_q  <= valid_n;
    end
  end

  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign phase     = phase_q;
  assign window    = window_of(phase_q);

endmodule
